reorder_buffer: RTL
===================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter RO_BUFFER_ENTRIES, default 8, meaning the number of entries (power of two; tag width TW = $clog2(RO_BUFFER_ENTRIES)).
REQ-002 SHALL have parameter NUM_CDB_ENTRIES, default 4, meaning the number of CDB broadcast lanes.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port flush  input  1  synchronous squash of all entries.
REQ-006 SHALL have port alloc  input  1  decoder request to allocate one entry.
REQ-007 SHALL have port alloc_rd  input  5  destination register of the allocating instruction.
REQ-008 SHALL have port alloc_tag  output  TW  tag that an allocation this cycle receives (the tail index).
REQ-009 SHALL have port rob_full  output  1  no allocation is accepted this cycle.
REQ-010 SHALL have port cdb_vals_i  input  cdb_t  NUM_CDB_ENTRIES lanes, each carrying {valid, tag[TW], value[32]}.
REQ-011 SHALL have port rob_reg_vals  output  32 x RO_BUFFER_ENTRIES  stored result per entry, for operand forwarding.
REQ-012 SHALL have port rob_commit_arr  output  1 x RO_BUFFER_ENTRIES  per-entry "busy and result ready" flag.
REQ-013 SHALL have ports commit_o (output, 1), commit_rd (output, 5), commit_val (output, 32) and commit_tag (output, TW), together forming the in-order retirement to the register file.

Function
REQ-014 SHALL operate as a circular queue with head, tail and count registers; head and tail SHALL wrap from RO_BUFFER_ENTRIES-1 to 0.
REQ-015 rob_full SHALL equal (count == RO_BUFFER_ENTRIES) and SHALL be combinational from registered state only.
REQ-016 When alloc=1, rob_full=0 and flush=0, the entry at tail SHALL be loaded with busy=1, ready=0, rd=alloc_rd and value=0, and tail SHALL advance on that edge.
REQ-017 An alloc while rob_full=1 SHALL be ignored with no state change; the decoder is responsible for stalling.
REQ-018 For each lane with valid=1 whose tag matches an entry with busy=1, that entry SHALL capture value and set ready=1 on the next edge; lanes addressing non-busy entries SHALL be ignored.
REQ-019 If two lanes carry the same tag in one cycle, the lowest-numbered lane SHALL win.
REQ-020 commit_o SHALL be asserted combinationally when the head entry has busy=1 and ready=1; commit_rd, commit_val and commit_tag SHALL then reflect the head entry.
REQ-021 On a commit, the head entry SHALL clear busy and ready and head SHALL advance on the same edge; at most one commit SHALL occur per cycle.
REQ-022 Result latency SHALL be 1 cycle: a CDB write at edge N makes the entry commit-eligible in the cycle following edge N, never in the same cycle.
REQ-023 When the queue is empty (count=0), commit_o SHALL be 0.
REQ-024 Simultaneous accepted alloc and commit SHALL leave count unchanged; the slot freed by a commit at full SHALL be allocatable only from the next cycle.
REQ-025 An entry with rd=0 SHALL still commit with commit_o=1 and commit_rd=0; suppressing the write is the register file's responsibility.
REQ-026 flush SHALL clear all busy/ready bits and set head=tail=count=0 on the next edge; flush SHALL override alloc, CDB writes and commit in that cycle.
REQ-027 rob_reg_vals[i] SHALL equal the stored value of entry i and rob_commit_arr[i] SHALL equal busy[i] AND ready[i], both purely from registered state.

Reset
REQ-028 Asserting rst SHALL immediately clear head, tail and count to 0, and SHALL clear every entry's busy, ready, rd and value to 0.
REQ-029 During and after reset, the outputs SHALL read rob_full=0, commit_o=0, alloc_tag=0, all rob_commit_arr bits 0 and all rob_reg_vals 0, including when rst is asserted mid-operation.

Structure
REQ-030 rob_entry_t {busy, ready, rd, value}, cdb_entry_t and cdb_t SHALL be defined in package structs; RO_BUFFER_ENTRIES and NUM_CDB_ENTRIES SHALL be defined in package macros.
REQ-031 The block SHALL be a single module with no sub-modules; the CDB tag-match logic SHALL be a generate loop over entries and lanes.

Verification
REQ-032 Allocate 8 entries with rd=1..8 -> alloc_tag steps through 0..7, rob_full=1 after the 8th; a 9th alloc is ignored and tail stays at 0.
REQ-033 Write CDB tag 2 (value 0xAA) before tags 0 and 1 -> no commit until tag 0 is ready; then three consecutive commits of tags 0, 1, 2 in order, with commit_val 0xAA on tag 2.
REQ-034 Lanes 0 and 3 both carry tag 5, with values 0x11 and 0x22 -> entry 5 holds 0x11.
REQ-035 At full, commit head and request alloc in the same cycle -> commit occurs and alloc is rejected; the alloc retried next cycle succeeds with the wrapped alloc_tag.
REQ-036 With 5 entries in flight, pulse flush together with alloc and a CDB write -> count=0, all rob_commit_arr bits 0, and the next alloc receives tag 0.
REQ-037 Assert rst asynchronously between clock edges with 3 entries busy -> all outputs reach their reset values before the next edge.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants and the entry / CDB lane record types used by the
// reorder buffer and anything that drives its result bus.
package macros;
  localparam int RO_BUFFER_ENTRIES = 8;
  localparam int NUM_CDB_ENTRIES   = 4;
  localparam int ROB_TW            = $clog2(RO_BUFFER_ENTRIES);
endpackage

package structs;
  import macros::*;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic [4:0]  rd;
    logic [31:0] value;
  } rob_entry_t;

  typedef struct packed {
    logic              valid;
    logic [ROB_TW-1:0] tag;
    logic [31:0]       value;
  } cdb_entry_t;

  typedef cdb_entry_t [NUM_CDB_ENTRIES-1:0] cdb_t;
endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order result capture
// from the CDB lanes, and in-order single-entry retirement from the head.
module reorder_buffer
  import structs::*;
#(
  parameter int RO_BUFFER_ENTRIES = macros::RO_BUFFER_ENTRIES,
  parameter int NUM_CDB_ENTRIES   = macros::NUM_CDB_ENTRIES
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                alloc,
  input  logic [4:0]                          alloc_rd,
  output logic [$clog2(RO_BUFFER_ENTRIES)-1:0] alloc_tag,
  output logic                                rob_full,
  input  cdb_t                                cdb_vals_i,
  output logic [RO_BUFFER_ENTRIES-1:0][31:0]  rob_reg_vals,
  output logic [RO_BUFFER_ENTRIES-1:0]        rob_commit_arr,
  output logic                                commit_o,
  output logic [4:0]                          commit_rd,
  output logic [31:0]                         commit_val,
  output logic [$clog2(RO_BUFFER_ENTRIES)-1:0] commit_tag
);

  localparam int TW = $clog2(RO_BUFFER_ENTRIES);
  localparam int CW = TW + 1;

  logic [TW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          do_alloc, do_commit;

  logic [RO_BUFFER_ENTRIES-1:0] busy_v, ready_v;
  logic [4:0]                   rd_v  [RO_BUFFER_ENTRIES];
  logic [31:0]                  val_v [RO_BUFFER_ENTRIES];

  assign rob_full  = (count == CW'(RO_BUFFER_ENTRIES));
  assign alloc_tag = tail;
  assign do_alloc  = alloc && !rob_full && !flush;

  assign commit_o   = busy_v[head] && ready_v[head] && (count != '0);
  assign commit_rd  = rd_v[head];
  assign commit_val = val_v[head];
  assign commit_tag = head;
  assign do_commit  = commit_o && !flush;

  // Queue pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_alloc)  tail <= tail + 1'b1;
      if (do_commit) head <= head + 1'b1;
      count <= count + CW'(do_alloc) - CW'(do_commit);
    end
  end

  // Per-entry storage with CDB tag match; lowest-numbered matching lane wins
  for (genvar e = 0; e < RO_BUFFER_ENTRIES; e++) begin : gen_entry
    rob_entry_t                 ent;
    logic [NUM_CDB_ENTRIES-1:0] lane_hit;
    logic [31:0]                lane_val;

    for (genvar ln = 0; ln < NUM_CDB_ENTRIES; ln++) begin : gen_lane
      assign lane_hit[ln] = cdb_vals_i[ln].valid && (cdb_vals_i[ln].tag == TW'(e));
    end

    always_comb begin
      lane_val = '0;
      for (int i = NUM_CDB_ENTRIES - 1; i >= 0; i--) begin
        if (lane_hit[i]) lane_val = cdb_vals_i[i].value;
      end
    end

    // An accepted alloc only ever targets a free slot, so it cannot collide
    // with a CDB capture or a commit on the same entry.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ent <= '0;
      end else if (flush) begin
        ent.busy  <= 1'b0;
        ent.ready <= 1'b0;
      end else if (do_alloc && tail == TW'(e)) begin
        ent.busy  <= 1'b1;
        ent.ready <= 1'b0;
        ent.rd    <= alloc_rd;
        ent.value <= '0;
      end else begin
        if ((|lane_hit) && ent.busy) begin
          ent.value <= lane_val;
          ent.ready <= 1'b1;
        end
        if (do_commit && head == TW'(e)) begin
          ent.busy  <= 1'b0;
          ent.ready <= 1'b0;
        end
      end
    end

    assign busy_v[e]         = ent.busy;
    assign ready_v[e]        = ent.ready;
    assign rd_v[e]           = ent.rd;
    assign val_v[e]          = ent.value;
    assign rob_reg_vals[e]   = ent.value;
    assign rob_commit_arr[e] = ent.busy && ent.ready;
  end

endmodule
